lc3_control_fsm: RTL

- Instruction-sequencing control unit for the LC-3 datapath.
- Each cycle it drives every gate, load, mux-select and memory-strobe input of the datapath.
- It steps fetch -> decode -> execute for the supported opcode subset and inserts programmable memory wait states.
- It sits directly upstream of the datapath and consumes the IR opcode bits and BEN that the datapath returns.

---
 rtl/lc3_control_fsm.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/lc3_control_fsm.sv
// LC-3 sequencing control: fetch/decode/execute with programmable memory wait states.
// All datapath controls are registered and follow the state register one-for-one.
module lc3_control_fsm #(
    parameter int unsigned MEM_WAIT = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic       cont,
    input  logic [3:0] opcode,
    input  logic       ir5,
    input  logic       ir11,
    input  logic       ben,
    output logic       GateMARMUX,
    output logic       GateMDR,
    output logic       GateALU,
    output logic       GatePC,
    output logic       LD_REG,
    output logic       LD_BEN,
    output logic       LD_CC,
    output logic       LD_IR,
    output logic       LD_MAR,
    output logic       LD_MDR,
    output logic       LD_PC,
    output logic       LD_LED,
    output logic       MARMUX,
    output logic       ADDR1MUX,
    output logic       SR2MUX,
    output logic       MIO_EN,
    output logic [1:0] PCMUX,
    output logic [1:0] DRMUX,
    output logic [1:0] ADDR2MUX,
    output logic [1:0] SR1MUX,
    output logic [1:0] ALUK,
    output logic       mem_rd,
    output logic       mem_wr
);

    localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT - 1);

    typedef enum logic [4:0] {
        S_HALTED, S_F1, S_F2, S_F3, S_DEC,
        S_ADD, S_AND, S_NOT, S_BR, S_BRT,
        S_JMP, S_JSR0, S_JSR1,
        S_LDR1, S_LDR2, S_LDR3,
        S_STR1, S_STR2, S_STR3,
        S_P1, S_P2
    } state_t;

    typedef struct packed {
        logic       gate_marmux;
        logic       gate_mdr;
        logic       gate_alu;
        logic       gate_pc;
        logic       ld_reg;
        logic       ld_ben;
        logic       ld_cc;
        logic       ld_ir;
        logic       ld_mar;
        logic       ld_mdr;
        logic       ld_pc;
        logic       ld_led;
        logic       marmux;
        logic       addr1mux;
        logic       sr2mux;
        logic       mio_en;
        logic [1:0] pcmux;
        logic [1:0] drmux;
        logic [1:0] addr2mux;
        logic [1:0] sr1mux;
        logic [1:0] aluk;
        logic       mem_rd;
        logic       mem_wr;
    } ctrl_t;

    state_t     state_q, state_d;
    logic [3:0] wait_q, wait_d;
    ctrl_t      ctrl_q, ctrl_d;
    logic       mem_state;
    logic       wait_done;

    // imm5 selection is handled inside the datapath
    logic unused_ir5;
    assign unused_ir5 = ir5;

    assign mem_state = (state_q == S_F2) || (state_q == S_LDR2) ||
                       (state_q == S_STR3);
    assign wait_done = (wait_q == WAIT_LAST);

    always_comb begin
        state_d = state_q;
        wait_d  = 4'd0;
        if (mem_state && !wait_done)
            wait_d = wait_q + 4'd1;
        case (state_q)
            S_HALTED: if (run) state_d = S_F1;
            S_F1:     state_d = S_F2;
            S_F2:     if (wait_done) state_d = S_F3;
            S_F3:     state_d = S_DEC;
            S_DEC: begin
                case (opcode)
                    4'b0001: state_d = S_ADD;
                    4'b0101: state_d = S_AND;
                    4'b1001: state_d = S_NOT;
                    4'b0000: state_d = S_BR;
                    4'b1100: state_d = S_JMP;
                    4'b0100: state_d = S_JSR0;
                    4'b0110: state_d = S_LDR1;
                    4'b0111: state_d = S_STR1;
                    4'b1101: state_d = S_P1;
                    default: state_d = S_F1;
                endcase
            end
            S_BR:     state_d = ben ? S_BRT : S_F1;
            S_JSR0:   state_d = S_JSR1;
            S_LDR1:   state_d = S_LDR2;
            S_LDR2:   if (wait_done) state_d = S_LDR3;
            S_STR1:   state_d = S_STR2;
            S_STR2:   state_d = S_STR3;
            S_STR3:   if (wait_done) state_d = S_F1;
            S_P1:     if (cont) state_d = S_P2;
            S_P2:     if (!cont) state_d = S_F1;
            S_ADD, S_AND, S_NOT, S_BRT, S_JMP, S_JSR1, S_LDR3:
                      state_d = S_F1;
            default:  state_d = S_HALTED;
        endcase
    end

    // Controls for the state about to be entered, so they line up with state_q
    always_comb begin
        ctrl_d = '0;
        case (state_d)
            S_F1: begin
                ctrl_d.gate_pc = 1'b1;
                ctrl_d.ld_mar  = 1'b1;
                ctrl_d.ld_pc   = 1'b1;
            end
            S_F2, S_LDR2: begin
                ctrl_d.mem_rd = 1'b1;
                ctrl_d.mio_en = 1'b1;
                ctrl_d.ld_mdr = 1'b1;
            end
            S_F3: begin
                ctrl_d.gate_mdr = 1'b1;
                ctrl_d.ld_ir    = 1'b1;
            end
            S_DEC: ctrl_d.ld_ben = 1'b1;
            S_ADD, S_AND, S_NOT: begin
                ctrl_d.sr1mux   = 2'b01;
                ctrl_d.aluk     = (state_d == S_ADD) ? 2'b00 :
                                  (state_d == S_AND) ? 2'b01 : 2'b10;
                ctrl_d.gate_alu = 1'b1;
                ctrl_d.ld_reg   = 1'b1;
                ctrl_d.ld_cc    = 1'b1;
            end
            S_BRT: begin
                ctrl_d.addr2mux = 2'b10;
                ctrl_d.pcmux    = 2'b10;
                ctrl_d.ld_pc    = 1'b1;
            end
            S_JMP: begin
                ctrl_d.sr1mux   = 2'b01;
                ctrl_d.addr1mux = 1'b1;
                ctrl_d.pcmux    = 2'b10;
                ctrl_d.ld_pc    = 1'b1;
            end
            S_JSR0: begin
                ctrl_d.gate_pc = 1'b1;
                ctrl_d.drmux   = 2'b01;
                ctrl_d.ld_reg  = 1'b1;
            end
            S_JSR1: begin
                if (ir11) begin
                    ctrl_d.addr2mux = 2'b11;
                end else begin
                    ctrl_d.sr1mux   = 2'b01;
                    ctrl_d.addr1mux = 1'b1;
                end
                ctrl_d.pcmux = 2'b10;
                ctrl_d.ld_pc = 1'b1;
            end
            S_LDR1, S_STR1: begin
                ctrl_d.sr1mux      = 2'b01;
                ctrl_d.addr1mux    = 1'b1;
                ctrl_d.addr2mux    = 2'b01;
                ctrl_d.marmux      = 1'b1;
                ctrl_d.gate_marmux = 1'b1;
                ctrl_d.ld_mar      = 1'b1;
            end
            S_LDR3: begin
                ctrl_d.gate_mdr = 1'b1;
                ctrl_d.ld_reg   = 1'b1;
                ctrl_d.ld_cc    = 1'b1;
            end
            S_STR2: begin
                ctrl_d.aluk     = 2'b11;
                ctrl_d.gate_alu = 1'b1;
                ctrl_d.ld_mdr   = 1'b1;
            end
            S_STR3: ctrl_d.mem_wr = 1'b1;
            S_P1:   ctrl_d.ld_led = 1'b1;
            default: ctrl_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_HALTED;
            wait_q  <= 4'd0;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign GateMARMUX = ctrl_q.gate_marmux;
    assign GateMDR    = ctrl_q.gate_mdr;
    assign GateALU    = ctrl_q.gate_alu;
    assign GatePC     = ctrl_q.gate_pc;
    assign LD_REG     = ctrl_q.ld_reg;
    assign LD_BEN     = ctrl_q.ld_ben;
    assign LD_CC      = ctrl_q.ld_cc;
    assign LD_IR      = ctrl_q.ld_ir;
    assign LD_MAR     = ctrl_q.ld_mar;
    assign LD_MDR     = ctrl_q.ld_mdr;
    assign LD_PC      = ctrl_q.ld_pc;
    assign LD_LED     = ctrl_q.ld_led;
    assign MARMUX     = ctrl_q.marmux;
    assign ADDR1MUX   = ctrl_q.addr1mux;
    assign SR2MUX     = ctrl_q.sr2mux;
    assign MIO_EN     = ctrl_q.mio_en;
    assign PCMUX      = ctrl_q.pcmux;
    assign DRMUX      = ctrl_q.drmux;
    assign ADDR2MUX   = ctrl_q.addr2mux;
    assign SR1MUX     = ctrl_q.sr1mux;
    assign ALUK       = ctrl_q.aluk;
    assign mem_rd     = ctrl_q.mem_rd;
    assign mem_wr     = ctrl_q.mem_wr;

endmodule
